// File: rtl/fifo_stall_buffer.sv
// +----------------------------------------------------------------------------+
// | fifo_stall_buffer: DW-bit FIFO with registered, stall-holding output,       |
// | occupancy/full/empty/almost-full flags and synchronous flush.               |
// | Optional sticky OVERFLOW/UNDERFLOW flags: define FIFO_STALL_ERR_FLAGS_EN.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_stall_buffer #(
    parameter int DW       = 4,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         clr,
    input  logic                         stall,
    input  logic [DW-1:0]                din,
    input  logic                         din_valid,
    output logic [DW-1:0]                dout,
    output logic                         dout_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int                 c_cnt_w    = $clog2(DEPTH + 1);
    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_level = c_cnt_w'(AF_LEVEL);

    logic [DW-1:0]      r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [DW-1:0]      r_dout;
    logic               r_dout_valid;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Flags decode from the count register only, so inputs never reach them.
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_pop   = en & ~stall & ~w_empty;
    assign w_push  = en & din_valid & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (!clr && w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (clr) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (en) begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_dout       <= r_mem[r_rd_ptr];
                r_dout_valid <= 1'b1;
                r_rd_ptr     <= r_rd_ptr + c_ptr_w'(1);
            end else if (!stall) begin
                r_dout_valid <= 1'b0;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

`ifdef FIFO_STALL_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_ovf_set = en & din_valid & w_full & ~w_pop;
    assign w_unf_set = en & ~stall & w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) r_overflow  <= 1'b1;
            if (w_unf_set) r_underflow <= 1'b1;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= c_af_level);

endmodule

`default_nettype wire

// File: tb/tb_fifo_stall_buffer.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_stall_buffer: directed and random stimulus against a queue model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_stall_buffer;

    localparam int DW       = 4;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = DEPTH - 1;
    localparam int CW       = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          clr;
    logic          stall;
    logic [DW-1:0] din;
    logic          din_valid;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference state: words waiting behind the output register.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;
`ifdef FIFO_STALL_ERR_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    fifo_stall_buffer #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clr         (clr),
        .stall       (stall),
        .din         (din),
        .din_valid   (din_valid),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_edge();
        bit was_full, was_empty, popped;
        if (clr) begin
            model_reset();
        end else if (en) begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            popped    = !stall && !was_empty;
            if (popped) begin
                m_dout  = q.pop_front();
                m_valid = 1'b1;
            end else if (!stall) begin
                m_valid = 1'b0;
            end
            if (din_valid && (!was_full || popped)) q.push_back(din);
            if (FLAGS_ON && din_valid && was_full && !popped) m_ovf = 1'b1;
            if (FLAGS_ON && !stall && was_empty) m_unf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
        if (m_valid || tag == "reset" || tag == "clr") chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AF_LEVEL));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    // Drive inputs, take one clock edge, then compare just after it.
    task automatic step(input string tag, input logic e, input logic c, input logic s,
                        input logic v, input logic [DW-1:0] d);
        en = e; clr = c; stall = s; din_valid = v; din = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] stream[7];
        logic [DW-1:0] fill[5];
        stream = '{4'd3, 4'd2, 4'd5, 4'd1, 4'd4, 4'd7, 4'd0};
        fill   = '{4'd6, 4'd2, 4'd1, 4'd3, 4'd5};

        clk = 1'b0; rst_n = 1'b0;
        en = 1'b0; clr = 1'b0; stall = 1'b0; din_valid = 1'b0; din = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then idle.
        for (int i = 0; i < 5; i++) step("idle", 1, 0, 0, 0, '0);

        // Stream through an empty, unstalled FIFO.
        for (int i = 0; i < 7; i++) begin
            step("stream", 1, 0, 0, 1, stream[i]);
            chk("stream.count_le1", 32'(count <= 1), 32'd1);
        end
        step("stream_tail", 1, 0, 0, 0, '0);
        chk("stream.last_word", 32'(dout), 32'd0);
        step("stream_drain", 1, 0, 0, 0, '0);

        // Stall and fill, then release.
        for (int i = 0; i < 5; i++) step("fill", 1, 0, 1, 1, fill[i]);
        chk("fill.full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step("release", 1, 0, 0, 0, '0);
            chk("release.order", 32'(dout), 32'(fill[i]));
        end
        step("release_empty", 1, 0, 0, 0, '0);

        // Full with push+pop: three laps of the pointers.
        for (int i = 1; i <= 4; i++) step("refill", 1, 0, 1, 1, DW'(i));
        step("fullpp", 1, 0, 0, 1, 4'd9);
        chk("fullpp.first", 32'(dout), 32'd1);
        for (int i = 0; i < 12; i++) step("laps", 1, 0, 0, 1, DW'($urandom));
        for (int i = 0; i < 5; i++) step("laps_drain", 1, 0, 0, 0, '0);

        // EN gating, then flush with three words held.
        for (int i = 0; i < 3; i++) step("fill3", 1, 0, 1, 1, DW'(i + 10));
        for (int i = 0; i < 3; i++) step("en_off", 0, 0, 0, 1, 4'hf);
        step("clr", 0, 1, 0, 1, 4'he);
        step("post_clr", 1, 0, 1, 0, '0);

        // Async reset mid-burst with two words stored and a valid output.
        step("burst", 1, 0, 0, 1, 4'd1);
        step("burst", 1, 0, 0, 1, 4'd2);
        step("burst", 1, 0, 1, 1, 4'd3);
        chk("burst.count2", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        #2 rst_n = 1'b1;
        step("rst_push8", 1, 0, 0, 1, 4'd8);
        step("rst_pop8", 1, 0, 0, 0, '0);
        chk("rst_push8.dout", 32'(dout), 32'd8);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_stall_buffer.md
# fifo_stall_buffer

Parametrised successor to the team's stall-aware FIFO decoder. Buffers DW-bit words written under a valid qualifier and presents them one at a time on a registered output that holds while STALL is high. Adds configurable depth, occupancy reporting, full/empty/almost-full flags, synchronous flush, and optional sticky error flags. Sits between a bursty producer and a stall-capable consumer in the datapath.

## Interface
- DW, 4, data word width in bits (≥1)
- DEPTH, 4, storage entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, ALMOST_FULL asserts when COUNT ≥ AF_LEVEL (1..DEPTH)
- CLK  in  1  single clock; all state updates on rising edge
- RSTN  in  1  reset; asynchronous, active-low
- EN  in  1  global enable; when 0 all state holds and inputs are ignored (CLR excepted)
- CLR  in  1  synchronous flush, highest priority after reset
- STALL  in  1  consumer stall; holds DOUT/DOUT_VALID
- DIN  in  DW  write data
- DIN_VALID  in  1  write request
- DOUT  out  DW  registered read data
- DOUT_VALID  out  1  DOUT carries a word in the current cycle
- COUNT  out  $clog2(DEPTH+1)  stored words, excluding the word on DOUT
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- ALMOST_FULL  out  1  COUNT ≥ AF_LEVEL
- OVERFLOW  out  1  sticky: push dropped while full
- UNDERFLOW  out  1  sticky: pop attempted while empty and not stalled

## Operation
- push = EN & DIN_VALID & (!FULL | pop); a push writes mem[wr_ptr] and increments wr_ptr mod DEPTH.
- pop = EN & !STALL & !EMPTY; a pop loads DOUT ← mem[rd_ptr], sets DOUT_VALID=1, and increments rd_ptr mod DEPTH.
- EN & !STALL & EMPTY: DOUT_VALID ← 0, DOUT holds its last value.
- STALL=1 or EN=0: DOUT and DOUT_VALID hold.
- COUNT update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle while FULL: both occur, COUNT stays DEPTH.
- Push and pop in the same cycle while EMPTY: the push stores, there is no pop, DOUT_VALID ← 0. There is no bypass path.
- Push while FULL with no pop: the word is dropped, and the pointers and COUNT are unchanged.
- CLR=1 (regardless of EN): pointers ← 0, COUNT ← 0, DOUT_VALID ← 0, DOUT ← 0, sticky flags cleared. Any push or pop in that cycle is ignored.
- FULL, EMPTY and ALMOST_FULL decode combinationally from the COUNT register only, never from the inputs.
- Word order is strict FIFO across pointer wrap.

## Timing
- Reset (RSTN=0, asynchronous): DOUT=0, DOUT_VALID=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0, pointers=0. Memory contents are don't-care.
- Reset mid-operation discards all stored words immediately. Release is synchronous to CLK via the normal edge.
- Latency into an empty, unstalled FIFO: DIN sampled at edge N appears on DOUT with DOUT_VALID=1 after edge N+1.
- Throughput: one word per cycle sustained when STALL=0 and EN=1.
- Deasserting STALL at edge N: the next word appears after edge N+1. A held word is presented exactly once per non-stalled cycle.
- Flags and COUNT reflect post-edge state in the same cycle.

## Configuration
- Macro FIFO_STALL_ERR_FLAGS_EN.
- Defined: OVERFLOW sets on any cycle where EN & DIN_VALID & FULL & !pop. UNDERFLOW sets on any cycle where EN & !STALL & EMPTY. Both hold until RSTN or CLR.
- Undefined: OVERFLOW and UNDERFLOW are tied to 0 and no flag registers exist. Drop-on-full behaviour is unchanged.

## Test plan
- Reset then idle: RSTN low 1 cycle, EN=1, STALL=0, DIN_VALID=0 for 5 cycles → DOUT=0, DOUT_VALID=0, EMPTY=1, COUNT=0 throughout, UNDERFLOW=1 only if the macro is defined.
- Stream: DW=4, DEPTH=4; push 3,2,5,1,4,7,0 on consecutive cycles with STALL=0 → DOUT shows 3,2,5,1,4,7,0 one cycle after each push, COUNT never exceeds 1.
- Stall and fill: STALL=1, push 6,2,1,3,5 → COUNT=4, FULL=1, ALMOST_FULL=1 at COUNT=3, word 5 dropped, OVERFLOW=1 (macro defined). Release STALL → DOUT 6,2,1,3, then DOUT_VALID=0.
- Full push+pop: FIFO full with 1,2,3,4, STALL=0, push 9 same cycle → COUNT stays 4, the DOUT sequence continues 1,2,3,4,9, with pointer wrap verified over 3 full laps.
- EN gating and CLR: EN=0 with DIN_VALID=1 and STALL=0 for 3 cycles → no state change. Then CLR with COUNT=3 → COUNT=0, DOUT_VALID=0, DOUT=0, flags cleared next cycle.
- Async reset mid-burst: assert RSTN between clock edges with COUNT=2, DOUT_VALID=1 → all outputs reach reset values before the next edge. After release, push 8 → DOUT=8 two edges later.
